// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared CPU constants and types for the fetch stage
package inst_fetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEF   = 32'h0000_0000;
  localparam word_t EXC_VECTOR_DEF = 32'h0000_0054;
  localparam word_t NOP            = 32'h0000_0000;
  localparam word_t PC_STEP        = 32'd4;

  // Which rule chose the next PC; the top uses it to decide IF/ID behaviour.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_HOLD,
    SEL_EXC,
    SEL_ERET,
    SEL_REDIR,
    SEL_FAULT
  } pc_sel_e;

  // Instruction words are 4-byte aligned; any low bit set is a fetch fault.
  function automatic logic misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - fixed-priority next-PC selection and misalignment check
module pc_next_sel
  import inst_fetch_pkg::*;
#(
  parameter word_t EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic    [WORD_W-1:0] pc,
  input  logic                 stall,
  input  logic                 redirect_en,
  input  logic    [WORD_W-1:0] redirect_pc,
  input  logic                 exc_req,
  input  logic                 eret_req,
  input  logic    [WORD_W-1:0] epc,
  output logic    [WORD_W-1:0] next_pc,
  output pc_sel_e              sel,
  output logic    [WORD_W-1:0] fault_addr
);

  word_t target;

  // Priority: exception, then eret, then redirect, then stall, else PC+4.
  always_comb begin
    next_pc    = pc + PC_STEP;
    sel        = SEL_SEQ;
    target     = eret_req ? epc : redirect_pc;
    fault_addr = target;
    if (exc_req) begin
      next_pc = EXC_VECTOR;
      sel     = SEL_EXC;
    end else if (eret_req || redirect_en) begin
      if (misaligned(target)) begin
        next_pc = EXC_VECTOR;
        sel     = SEL_FAULT;
      end else begin
        next_pc = target;
        sel     = eret_req ? SEL_ERET : SEL_REDIR;
      end
    end else if (stall) begin
      next_pc = pc;
      sel     = SEL_HOLD;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC register and IF/ID register
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter word_t RESET_PC   = RESET_PC_DEF,
  parameter word_t EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] Iaddr,
  input  logic [WORD_W-1:0] Inst,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [WORD_W-1:0] epc,
  output logic [WORD_W-1:0] if_inst,
  output logic [WORD_W-1:0] if_pc,
  output logic              if_valid,
  output logic              fetch_abend,
  output logic [WORD_W-1:0] bad_addr
);

  word_t   pc;
  word_t   next_pc;
  word_t   fault_addr;
  pc_sel_e sel;

  assign Iaddr = pc;

  pc_next_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_sel (
    .pc          (pc),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .next_pc     (next_pc),
    .sel         (sel),
    .fault_addr  (fault_addr)
  );

  // PC and IF/ID update; any control transfer squashes the word fetched this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_inst     <= NOP;
      if_pc       <= RESET_PC;
      if_valid    <= 1'b0;
      fetch_abend <= 1'b0;
      bad_addr    <= '0;
    end else begin
      pc          <= next_pc;
      fetch_abend <= (sel == SEL_FAULT);
      if (sel == SEL_FAULT) begin
        bad_addr <= fault_addr;
      end
      case (sel)
        SEL_SEQ: begin
          if_inst  <= Inst;
          if_pc    <= pc;
          if_valid <= 1'b1;
        end
        SEL_HOLD: begin
          if_inst  <= if_inst;
          if_pc    <= if_pc;
          if_valid <= if_valid;
        end
        default: begin
          if_inst  <= NOP;
          if_pc    <= pc;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC    = 32'h0000_0054;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Iaddr;
  logic [31:0] Inst;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        fetch_abend;
  logic [31:0] bad_addr;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_pc, m_inst, m_ifpc, m_bad;
  logic        m_valid, m_abend;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  assign Inst = mem_word(Iaddr);

  inst_fetch #(
    .RESET_PC   (RST_PC),
    .EXC_VECTOR (EXC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Iaddr       (Iaddr),
    .Inst        (Inst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .fetch_abend (fetch_abend),
    .bad_addr    (bad_addr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: next state straight from the fetch rules.
  always @(posedge clk) begin : model
    logic [31:0] tgt;
    if (rst) begin
      m_pc <= RST_PC; m_inst <= '0; m_ifpc <= RST_PC;
      m_valid <= 1'b0; m_abend <= 1'b0; m_bad <= '0;
    end else begin
      m_abend <= 1'b0;
      if (exc_req) begin
        m_pc <= EXC; m_valid <= 1'b0; m_inst <= '0; m_ifpc <= m_pc;
      end else if (eret_req || redirect_en) begin
        tgt = eret_req ? epc : redirect_pc;
        if (tgt % 4 != 0) begin
          m_pc <= EXC; m_abend <= 1'b1; m_bad <= tgt;
        end else begin
          m_pc <= tgt;
        end
        m_valid <= 1'b0; m_inst <= '0; m_ifpc <= m_pc;
      end else if (!stall) begin
        m_inst <= mem_word(m_pc); m_ifpc <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
      end
    end
  end

  // Compare DUT against the model on every falling edge once the model is defined.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_iaddr", Iaddr, m_pc);
      chk("m_if_inst", if_inst, m_inst);
      chk("m_if_pc", if_pc, m_ifpc);
      chk("m_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("m_abend", {31'b0, fetch_abend}, {31'b0, m_abend});
      chk("m_bad_addr", bad_addr, m_bad);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 1'b0; redirect_en = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
  endtask

  task automatic jump(input logic [31:0] t);
    idle(); redirect_en = 1'b1; redirect_pc = t; cyc(); idle();
  endtask

  function automatic logic [31:0] pick_target();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom & 32'h0000_0FFC;
    if (r < 8) return ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
    return 32'hFFFF_FFF0 | ($urandom & 32'hC);
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_iaddr", Iaddr, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_bad", bad_addr, 32'h0);

    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("seq_iaddr", Iaddr, 32'(4 * i));
      chk("seq_if_pc", if_pc, 32'(4 * (i - 1)));
      chk("seq_if_valid", {31'b0, if_valid}, 32'h1);
      chk("seq_if_inst", if_inst, mem_word(32'(4 * (i - 1))));
    end
    cyc();
    chk("pre_stall_iaddr", Iaddr, 32'h14);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_iaddr", Iaddr, 32'h14);
      chk("stall_if_pc", if_pc, 32'h10);
    end
    stall = 1'b0;
    cyc();
    chk("resume_iaddr", Iaddr, 32'h18);
    chk("resume_if_pc", if_pc, 32'h14);

    jump(32'h08);
    chk("redir8_iaddr", Iaddr, 32'h08);
    chk("redir8_if_pc_squashed", if_pc, 32'h18);
    jump(32'h14);
    chk("redir14_iaddr", Iaddr, 32'h14);
    chk("redir14_bubble", {31'b0, if_valid}, 32'h0);
    chk("redir14_nop", if_inst, 32'h0);
    cyc();
    chk("redir14_if_pc", if_pc, 32'h14);
    chk("redir14_valid", {31'b0, if_valid}, 32'h1);

    jump(32'h5C);
    exc_req = 1'b1; stall = 1'b1;
    cyc(); idle();
    chk("exc_iaddr", Iaddr, 32'h54);
    chk("exc_bubble", {31'b0, if_valid}, 32'h0);
    cyc();
    chk("exc_then_seq", Iaddr, 32'h58);
    eret_req = 1'b1; epc = 32'h60;
    cyc(); idle();
    chk("eret_iaddr", Iaddr, 32'h60);
    chk("eret_bubble", {31'b0, if_valid}, 32'h0);
    cyc();
    chk("eret_if_pc", if_pc, 32'h60);

    jump(32'h0000_1236);
    chk("mis_iaddr", Iaddr, 32'h54);
    chk("mis_abend", {31'b0, fetch_abend}, 32'h1);
    chk("mis_bad", bad_addr, 32'h0000_1236);
    cyc();
    chk("mis_abend_pulse", {31'b0, fetch_abend}, 32'h0);
    chk("mis_bad_held", bad_addr, 32'h0000_1236);

    exc_req = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h0000_0777;
    cyc(); idle();
    chk("exc_vs_mis_iaddr", Iaddr, 32'h54);
    chk("exc_vs_mis_abend", {31'b0, fetch_abend}, 32'h0);
    chk("exc_vs_mis_bad", bad_addr, 32'h0000_1236);

    eret_req = 1'b1; epc = 32'h61;
    cyc(); idle();
    chk("eret_mis_abend", {31'b0, fetch_abend}, 32'h1);
    chk("eret_mis_bad", bad_addr, 32'h61);

    jump(32'hFFFF_FFFC);
    chk("wrap_pre", Iaddr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_iaddr", Iaddr, 32'h0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    stall = 1'b1;
    cyc();
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40;
    cyc();
    chk("rst_mid_iaddr", Iaddr, 32'h0);
    chk("rst_mid_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_mid_bad", bad_addr, 32'h0);
    rst = 1'b0; idle();
    cyc();
    chk("first_after_rst_inst", if_inst, mem_word(32'h0));
    chk("first_after_rst_valid", {31'b0, if_valid}, 32'h1);

    for (int n = 0; n < 2000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      exc_req     = ($urandom_range(0, 15) == 0);
      eret_req    = ($urandom_range(0, 15) == 0);
      redirect_en = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect_pc = pick_target();
      epc         = pick_target();
      cyc();
    end
    rst = 1'b0; idle();
    cyc();
    cyc();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0054, is the exception/interrupt handler entry address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 Iaddr  output  32  fetch address to instruction memory; equals the PC register, never combinational from inputs.
REQ-006 Inst  input  32  instruction word from instruction memory; valid in the same cycle as Iaddr (combinational read).
REQ-007 stall  input  1  hold PC and IF/ID outputs.
REQ-008 redirect_en / redirect_pc  input  1/32  taken jump or branch target from decode.
REQ-009 exc_req  input  1  exception or interrupt accepted; fetch goes to EXC_VECTOR.
REQ-010 eret_req / epc  input  1/32  return from exception to epc.
REQ-011 if_inst / if_pc / if_valid  output  32/32/1  IF/ID register: fetched word, its address, and a valid flag.
REQ-012 fetch_abend / bad_addr  output  1/32  misaligned-target fault pulse and the offending address.

Function
REQ-013 The next PC SHALL be selected by fixed priority: exc_req > eret_req > redirect_en > stall > sequential (PC+4).
REQ-014 Sequential: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); if_inst <= Inst, if_pc <= PC, if_valid <= 1.
REQ-015 Stall with no higher-priority event SHALL hold PC, if_inst, if_pc and if_valid unchanged.
REQ-016 exc_req SHALL load PC <= EXC_VECTOR and clear if_valid next cycle (squash the wrong-path fetch), regardless of stall.
REQ-017 eret_req SHALL load PC <= epc and clear if_valid, regardless of stall.
REQ-018 redirect_en SHALL load PC <= redirect_pc and clear if_valid, regardless of stall.
REQ-019 A redirect/eret target with bits [1:0] != 0 SHALL NOT be loaded; PC <= EXC_VECTOR, fetch_abend pulses 1 cycle, and bad_addr <= the target.
REQ-020 bad_addr SHALL hold its value until the next misaligned fault or reset.
REQ-021 When if_valid = 0, if_inst SHALL read 32'h0000_0000 (NOP), and if_pc SHALL be the squashed address.
REQ-022 Simultaneous exc_req and a misaligned redirect SHALL take exc_req only, with no fetch_abend.
REQ-023 Latency: an instruction at address A appears on if_inst one cycle after Iaddr = A with no stall.
REQ-024 The first valid instruction after reset release SHALL be the word at RESET_PC, one cycle after rst deasserts.

Reset
REQ-025 On rst: PC <= RESET_PC, if_inst <= 0, if_pc <= RESET_PC, if_valid <= 0, fetch_abend <= 0, bad_addr <= 0.
REQ-026 rst SHALL override every other input in the same cycle, including an in-progress stall or redirect.

Structure
REQ-027 RESET_PC, EXC_VECTOR, the NOP encoding and the 32-bit word width belong in the shared CPU package.
REQ-028 Next-PC selection and the misalignment check SHALL form one combinational sub-module, pc_next_sel; the PC and IF/ID registers stay in inst_fetch.
REQ-029 Target RTL size: 120-250 lines, no memories inside the block.

Verification
REQ-030 Reset then 5 free-running cycles -> Iaddr 0,4,8,C,10; if_pc lags by one cycle; if_valid rises one cycle after rst drops.
REQ-031 stall high for 3 cycles at PC=0x14 -> Iaddr and IF/ID frozen; PC resumes at 0x18 after stall drops.
REQ-032 redirect_en with redirect_pc=0x14 at PC=0x08 -> next Iaddr 0x14, if_valid=0 for one cycle, then 0x14 appears on if_pc.
REQ-033 exc_req and stall together at PC=0x5C -> Iaddr 0x54 next cycle; eret_req with epc=0x60 later -> Iaddr 0x60, one bubble each.
REQ-034 redirect_pc=0x0000_1236 -> Iaddr 0x54, fetch_abend=1 for exactly one cycle, bad_addr=0x0000_1236 held.
REQ-035 PC forced to 0xFFFF_FFFC via redirect -> next sequential Iaddr 0x0000_0000; rst asserted mid-stall -> PC=0, if_valid=0 next cycle.
